seq_tx: RTL and testbench

- Serial pattern transmitter. It drives a one-bit serial line with a programmable WIDTH-bit pattern, MSB first, repeated a programmable number of times, with optional zero gap bits between frames.
- It is the sending end of the team's serial sequence-detect path. Its output `w` connects directly to the 1101 detector's `w` input.
- On the DE1_SoC top level it is clocked by the divided clock. `pattern` comes from SW[4:1], `reps` from SW[8:5], `start` from ~KEY[1], and `w` goes to LEDR[1].

---
 rtl/seq_tx_pkg.sv | 15 +
 rtl/seq_tx_piso_shift.sv | 29 ++
 rtl/seq_tx.sv | 178 +++++++++++++++++
 tb/tb_seq_tx.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and defaults for the serial pattern transmitter.
package seq_tx_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, GAP} tx_state_t;

   localparam int unsigned WIDTH_DEF = 4;
   localparam int unsigned REP_W_DEF = 4;
   localparam int unsigned GAP_DEF   = 0;

   // Counter width able to hold 0..n, never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n + 1);
   endfunction

endpackage

// File: rtl/seq_tx_piso_shift.sv
// Parallel-in serial-out register: load, left-shift enable, async reset, MSB tap.
module piso_shift
   import seq_tx_pkg::*;
#(
   parameter int unsigned WIDTH = WIDTH_DEF
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             load_i,
   input  logic             shift_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             msb_o
);

   logic [WIDTH-1:0] sr_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sr_q <= '0;
      end else if (load_i) begin
         sr_q <= data_i;
      end else if (shift_i) begin
         sr_q <= {sr_q[WIDTH-2:0], 1'b0};
      end
   end

   assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seq_tx.sv
// Serial pattern transmitter: sends a latched WIDTH-bit pattern MSB first,
// reps times, with optional zero gap bits between frames.
module seq_tx
   import seq_tx_pkg::*;
#(
   parameter int unsigned WIDTH    = WIDTH_DEF,
   parameter int unsigned GAP_BITS = GAP_DEF,
   parameter int unsigned REP_W    = REP_W_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [WIDTH-1:0] pattern,
   input  logic [REP_W-1:0] reps,
   output logic             w,
   output logic             busy,
   output logic             done,
   output logic [REP_W-1:0] frame_idx
);

   localparam int unsigned BCW = $clog2(WIDTH);
   localparam int unsigned GCW = cnt_width(GAP_BITS);
   localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
   localparam logic [GCW-1:0] GAP_LAST = GCW'(GAP_BITS);

   tx_state_t        state_q, state_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [REP_W-1:0] reps_q, reps_d;
   logic [REP_W-1:0] frame_q, frame_d;
   logic [BCW-1:0]   bit_q, bit_d;
   logic [GCW-1:0]   gap_q, gap_d;
   logic             w_q, w_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   logic             sr_load, sr_shift, sr_msb;
   logic [WIDTH-1:0] sr_data;
   logic [REP_W:0]   next_frame;
   logic             frames_left;

   // The shift register holds only the bits not yet on the line, so its MSB
   // is always the next bit to drive while w_q carries the current one.
   piso_shift #(.WIDTH(WIDTH)) u_piso (
      .clk_i   (clk),
      .rst_i   (reset),
      .load_i  (sr_load),
      .shift_i (sr_shift),
      .data_i  (sr_data),
      .msb_o   (sr_msb)
   );

   assign next_frame  = {1'b0, frame_q} + (REP_W+1)'(1);
   assign frames_left = next_frame < {1'b0, reps_q};

   always_comb begin
      state_d  = state_q;
      pat_d    = pat_q;
      reps_d   = reps_q;
      frame_d  = frame_q;
      bit_d    = bit_q;
      gap_d    = gap_q;
      w_d      = w_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      sr_load  = 1'b0;
      sr_shift = 1'b0;
      sr_data  = {pat_q[WIDTH-2:0], 1'b0};

      if (abort) begin
         state_d = IDLE;
         w_d     = 1'b0;
         busy_d  = 1'b0;
         frame_d = '0;
         bit_d   = '0;
         gap_d   = '0;
      end else begin
         case (state_q)
            IDLE: begin
               w_d     = 1'b0;
               busy_d  = 1'b0;
               frame_d = '0;
               if (start) begin
                  if (reps != '0) begin
                     pat_d   = pattern;
                     reps_d  = reps;
                     state_d = SHIFT;
                     busy_d  = 1'b1;
                     bit_d   = '0;
                     w_d     = pattern[WIDTH-1];
                     sr_load = 1'b1;
                     sr_data = {pattern[WIDTH-2:0], 1'b0};
                  end else begin
                     done_d = 1'b1;
                  end
               end
            end

            SHIFT: begin
               if (bit_q != BIT_LAST) begin
                  w_d      = sr_msb;
                  sr_shift = 1'b1;
                  bit_d    = bit_q + BCW'(1);
               end else if (frames_left) begin
                  if (GAP_BITS > 0) begin
                     state_d = GAP;
                     w_d     = 1'b0;
                     gap_d   = GCW'(1);
                  end else begin
                     w_d     = pat_q[WIDTH-1];
                     sr_load = 1'b1;
                     bit_d   = '0;
                     frame_d = next_frame[REP_W-1:0];
                  end
               end else begin
                  state_d = IDLE;
                  w_d     = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  frame_d = '0;
                  bit_d   = '0;
               end
            end

            GAP: begin
               w_d = 1'b0;
               if (gap_q == GAP_LAST) begin
                  state_d = SHIFT;
                  w_d     = pat_q[WIDTH-1];
                  sr_load = 1'b1;
                  bit_d   = '0;
                  gap_d   = '0;
                  frame_d = next_frame[REP_W-1:0];
               end else begin
                  gap_d = gap_q + GCW'(1);
               end
            end

            default: begin
               state_d = IDLE;
               w_d     = 1'b0;
               busy_d  = 1'b0;
               frame_d = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         pat_q   <= '0;
         reps_q  <= '0;
         frame_q <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         w_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         reps_q  <= reps_d;
         frame_q <= frame_d;
         bit_q   <= bit_d;
         gap_q   <= gap_d;
         w_q     <= w_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign w         = w_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign frame_idx = frame_q;

endmodule

// File: tb/tb_seq_tx.sv
// Bench for seq_tx: two instances (no gap, two gap bits) share stimulus and are
// compared cycle by cycle against a stream model derived from frame arithmetic.
module tb_seq_tx;

   localparam int W  = 4;
   localparam int RW = 4;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [1:0] abort;
   logic [3:0] pattern;
   logic [3:0] reps;

   logic       w0, busy0, done0;
   logic [3:0] fidx0;
   logic       w2, busy2, done2;
   logic [3:0] fidx2;

   logic [6:0] obs [2];
   logic       w0_hist [$];
   logic       w2_hist [$];

   int n_checks = 0;
   int n_errors = 0;

   seq_tx #(.WIDTH(W), .GAP_BITS(0), .REP_W(RW)) dut0 (
      .clk(clk), .reset(reset), .start(start), .abort(abort[0]),
      .pattern(pattern), .reps(reps),
      .w(w0), .busy(busy0), .done(done0), .frame_idx(fidx0)
   );

   seq_tx #(.WIDTH(W), .GAP_BITS(2), .REP_W(RW)) dut2 (
      .clk(clk), .reset(reset), .start(start), .abort(abort[1]),
      .pattern(pattern), .reps(reps),
      .w(w2), .busy(busy2), .done(done2), .frame_idx(fidx2)
   );

   always_comb begin
      obs[0] = {w0, busy0, done0, fidx0};
      obs[1] = {w2, busy2, done2, fidx2};
   end

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic int gap_of(input int i);
      return (i == 0) ? 0 : 2;
   endfunction

   function automatic int tx_len(input int g, input int r);
      return (r == 0) ? 0 : r * W + (r - 1) * g;
   endfunction

   // Expected {w, busy, done, frame_idx} at sample k (k=1 is just after the start edge).
   function automatic logic [6:0] model(input int g, input logic [3:0] pat,
                                        input int r, input int k);
      int len, pos, per, f, off;
      len = tx_len(g, r);
      if (r == 0) return (k == 1) ? 7'b0010000 : 7'b0;
      if (k >= 1 && k <= len) begin
         pos = k - 1;
         per = W + g;
         f   = pos / per;
         off = pos % per;
         return {(off < W) ? pat[W-1-off] : 1'b0, 1'b1, 1'b0, 4'(f)};
      end
      if (k == len + 1) return 7'b0010000;
      return 7'b0;
   endfunction

   task automatic test_transfer(input logic [3:0] pat, input int r,
                                input bit junk, input string name);
      int         len0, lmax;
      logic [6:0] e;
      len0 = tx_len(0, r);
      lmax = tx_len(2, r);
      abort   = 2'b00;
      pattern = pat;
      reps    = 4'(r);
      start   = 1'b1;
      w0_hist.delete();
      w2_hist.delete();
      tick();
      for (int k = 1; k <= lmax + 2; k++) begin
         w0_hist.push_back(w0);
         w2_hist.push_back(w2);
         for (int i = 0; i < 2; i++) begin
            e = model(gap_of(i), pat, r, k);
            n_checks++;
            if (obs[i] !== e) begin
               n_errors++;
               $display("FAIL %s k=%0d dut_gap%0d: got %b expected %b", name, k, gap_of(i), obs[i], e);
            end
         end
         if (junk && k <= len0) begin
            start   = 1'($urandom);
            pattern = 4'($urandom);
            reps    = 4'($urandom);
         end else begin
            start = 1'b0;
         end
         tick();
      end
      start = 1'b0;
   endtask

   task automatic test_reset;
      start = 1'b0; abort = 2'b00; pattern = '0; reps = '0; reset = 1'b0;
      #1 reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_init dut_gap%0d: got %b expected %b", gap_of(i), obs[i], 7'b0);
         end
      end
      @(negedge clk) reset = 1'b0;
      tick();
      pattern = 4'hF; reps = 4'd3; start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      n_checks++;
      if (busy0 !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_pre_busy: got %b expected 1", busy0);
      end
      #3 reset = 1'b1;
      #1;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_async dut_gap%0d: got %b expected %b", gap_of(i), obs[i], 7'b0);
         end
      end
      @(negedge clk) reset = 1'b0;
      tick();
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_no_done dut_gap%0d: got %b expected %b", gap_of(i), obs[i], 7'b0);
         end
      end
   endtask

   task automatic test_single;
      test_transfer(4'b1101, 1, 1'b0, "single");
   endtask

   task automatic test_detector;
      logic [3:0] win;
      int         hits;
      test_transfer(4'b1101, 3, 1'b0, "detector");
      win  = '0;
      hits = 0;
      foreach (w0_hist[j]) begin
         win = {win[2:0], w0_hist[j]};
         if (win == 4'b1101) hits++;
      end
      n_checks++;
      if (hits !== 3) begin
         n_errors++;
         $display("FAIL detector_hits: got %0d expected 3", hits);
      end
   endtask

   task automatic test_gap;
      logic [9:0] seq;
      test_transfer(4'b1011, 2, 1'b0, "gap");
      seq = '0;
      for (int j = 0; j < 10; j++) seq = {seq[8:0], w2_hist[j]};
      n_checks++;
      if (seq !== 10'b1011001011) begin
         n_errors++;
         $display("FAIL gap_stream: got %b expected %b", seq, 10'b1011001011);
      end
   endtask

   task automatic test_reps_zero;
      test_transfer(4'($urandom), 0, 1'b0, "reps_zero");
   endtask

   task automatic test_random;
      for (int n = 0; n < 20; n++)
         test_transfer(4'($urandom), int'($urandom_range(6, 1)), 1'b1, "random");
   endtask

   task automatic test_abort;
      logic [3:0] pat;
      logic [6:0] e;
      int         ab [2];
      pat   = 4'($urandom);
      ab[0] = W + gap_of(0) + 2;
      ab[1] = W + gap_of(1) + 2;
      abort = 2'b00; pattern = pat; reps = 4'd2; start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= ab[1] + 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            e = (k <= ab[i]) ? model(gap_of(i), pat, 2, k) : 7'b0;
            n_checks++;
            if (obs[i] !== e) begin
               n_errors++;
               $display("FAIL abort k=%0d dut_gap%0d: got %b expected %b", k, gap_of(i), obs[i], e);
            end
         end
         abort = {1'(k == ab[1]), 1'(k == ab[0])};
         tick();
      end
      abort = 2'b00;
      test_transfer(pat, 2, 1'b0, "after_abort");
   endtask

   task automatic test_back_to_back;
      logic [3:0] pat;
      logic [6:0] e;
      int         r, len, pos, cycles;
      pat = 4'($urandom);
      r   = int'($urandom_range(3, 1));
      abort = 2'b00; pattern = pat; reps = 4'(r); start = 1'b1;
      cycles = 2 * (tx_len(2, r) + 1) + 1;
      tick();
      for (int k = 1; k <= cycles; k++) begin
         for (int i = 0; i < 2; i++) begin
            len = tx_len(gap_of(i), r);
            pos = (k - 1) % (len + 1);
            e   = model(gap_of(i), pat, r, pos + 1);
            n_checks++;
            if (obs[i] !== e) begin
               n_errors++;
               $display("FAIL back_to_back k=%0d dut_gap%0d: got %b expected %b", k, gap_of(i), obs[i], e);
            end
         end
         tick();
      end
      start = 1'b0;
      abort = 2'b11;
      tick();
      abort = 2'b00;
      for (int i = 0; i < 2; i++) begin
         n_checks++;
         if (obs[i] !== 7'b0) begin
            n_errors++;
            $display("FAIL b2b_abort dut_gap%0d: got %b expected %b", gap_of(i), obs[i], 7'b0);
         end
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_detector();
      test_gap();
      test_reps_zero();
      test_random();
      test_abort();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
